elastic_pipeline: RTL and testbench



---
 rtl/elastic_pipeline.sv | 147 ++++++++++++++
 tb/tb_elastic_pipeline.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// Chain of valid/ready register slices (single-entry or two-entry skid) that retimes a stream.
// Optional occupancy counter is enabled by defining ELASTIC_PIPELINE_OCCUPANCY_EN.
module elastic_pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4,
  parameter int SKID   = 1,
  localparam int OCC_W = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [OCC_W-1:0] o_occupancy
);

  // Handshake: a word moves across any boundary exactly on a rising edge where
  // valid && ready are both high; valid never depends on ready of the same boundary.

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = i_clk ^ i_rst;
    assign o_valid       = i_valid;
    assign o_data        = i_data;
    assign o_ready       = i_ready;
    assign o_occupancy   = '0;
  end else begin : g_pipe
    // Boundary k sits between stage k-1 and stage k; boundary 0 is the input port.
    logic             vld [STAGES+1];
    logic             rdy [STAGES+1];
    logic [WIDTH-1:0] dat [STAGES+1];
    logic [1:0]       dbg_state [STAGES];

    assign vld[0]      = i_valid;
    assign dat[0]      = i_data;
    assign o_ready     = rdy[0];
    assign o_valid     = vld[STAGES];
    assign o_data      = dat[STAGES];
    assign rdy[STAGES] = i_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (SKID == 0) begin : g_simple
        typedef enum logic {S_EMPTY, S_FULL} state_t;
        state_t           state_q, state_d;
        logic [WIDTH-1:0] data_q;
        logic             accept, drain;

        assign accept = vld[k] && rdy[k];
        assign drain  = (state_q == S_FULL) && rdy[k+1];

        always_ff @(posedge i_clk) begin
          if (i_rst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
          end else begin
            state_q <= state_d;
            if (accept) data_q <= dat[k];
          end
        end

        always_comb begin
          state_d = state_q;
          case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (drain && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
          endcase
        end

        assign rdy[k]       = (state_q == S_EMPTY) || rdy[k+1];
        assign vld[k+1]     = (state_q == S_FULL);
        assign dat[k+1]     = data_q;
        assign dbg_state[k] = {1'b0, state_q};
      end else begin : g_skid
        typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
        state_t           state_q, state_d;
        logic [WIDTH-1:0] main_q, skid_q;
        logic             rdy_q;
        logic             accept, drain;

        assign accept = vld[k] && rdy_q;
        assign drain  = (state_q != S_EMPTY) && rdy[k+1];

        always_ff @(posedge i_clk) begin
          if (i_rst) begin
            state_q <= S_EMPTY;
            rdy_q   <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
          end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != S_TWO);
            case (state_q)
              S_EMPTY: if (accept) main_q <= dat[k];
              S_ONE: begin
                if (accept && drain) main_q <= dat[k];
                else if (accept)     skid_q <= dat[k];
              end
              S_TWO:   if (drain) main_q <= skid_q;
              default: ;
            endcase
          end
        end

        always_comb begin
          state_d = state_q;
          case (state_q)
            S_EMPTY: if (accept) state_d = S_ONE;
            S_ONE: begin
              if (accept && !drain)      state_d = S_TWO;
              else if (drain && !accept) state_d = S_EMPTY;
            end
            S_TWO:   if (drain) state_d = S_ONE;
            default: state_d = S_EMPTY;
          endcase
        end

        assign rdy[k]       = rdy_q;
        assign vld[k+1]     = (state_q != S_EMPTY);
        assign dat[k+1]     = main_q;
        assign dbg_state[k] = state_q;
      end
    end

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    logic [OCC_W-1:0] occ_q;
    logic             in_xfer, out_xfer;

    assign in_xfer  = i_valid && rdy[0];
    assign out_xfer = vld[STAGES] && i_ready;

    always_ff @(posedge i_clk) begin
      if (i_rst)                     occ_q <= '0;
      else if (in_xfer && !out_xfer) occ_q <= occ_q + 1'b1;
      else if (out_xfer && !in_xfer) occ_q <= occ_q - 1'b1;
    end

    assign o_occupancy = occ_q;
`else
    assign o_occupancy = '0;
`endif
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: skid chain (4 stages), simple chain (3 stages) and pass-through.
module tb_elastic_pipeline;

  logic clk, rst;

  logic       valid_a, ready_a, ovalid_a, iready_a;
  logic [7:0] data_a, odata_a;
  logic [3:0] occ_a;
  logic       valid_b, ready_b, ovalid_b, iready_b;
  logic [7:0] data_b, odata_b;
  logic [2:0] occ_b;
  logic       valid_c, ready_c, ovalid_c, iready_c;
  logic [7:0] data_c, odata_c;
  logic [0:0] occ_c;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int vectors = 0;
  int miscompares = 0;
  int acc_a = 0;
  int out_b = 0;
  logic acc_last_b = 1'b0;
  logic held_b = 1'b0;
  logic [7:0] held_data_b = '0;

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  localparam bit OCC_ON = 1'b1;
`else
  localparam bit OCC_ON = 1'b0;
`endif

  elastic_pipeline #(.WIDTH(8), .STAGES(4), .SKID(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .o_ready(ready_a), .i_data(data_a),
    .o_valid(ovalid_a), .i_ready(iready_a), .o_data(odata_a), .o_occupancy(occ_a));

  elastic_pipeline #(.WIDTH(8), .STAGES(3), .SKID(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .o_ready(ready_b), .i_data(data_b),
    .o_valid(ovalid_b), .i_ready(iready_b), .o_data(odata_b), .o_occupancy(occ_b));

  elastic_pipeline #(.WIDTH(8), .STAGES(0), .SKID(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_c), .o_ready(ready_c), .i_data(data_c),
    .o_valid(ovalid_c), .i_ready(iready_c), .o_data(odata_c), .o_occupancy(occ_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // accepted input words become expected output words
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      exp_a.push_back(data_a);
      acc_a++;
    end
    acc_last_b = !rst && valid_b && ready_b;
    if (acc_last_b) exp_b.push_back(data_b);
  end

  // output monitors
  always @(negedge clk) begin
    if (!rst && ovalid_a && iready_a) begin
      if (exp_a.size() == 0) check("a_unexpected_word", {24'd0, odata_a}, 32'hffff_ffff);
      else check("a_data", {24'd0, odata_a}, {24'd0, exp_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (held_b) begin
        check("b_stall_valid", {31'd0, ovalid_b}, 32'd1);
        check("b_stall_data", {24'd0, odata_b}, {24'd0, held_data_b});
      end
      if (ovalid_b && iready_b) begin
        out_b++;
        if (exp_b.size() == 0) check("b_unexpected_word", {24'd0, odata_b}, 32'hffff_ffff);
        else check("b_data", {24'd0, odata_b}, {24'd0, exp_b.pop_front()});
      end
      held_b      = ovalid_b && !iready_b;
      held_data_b = odata_b;
    end else begin
      held_b = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || ovalid_a) && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, n < 60}, 32'd1);
  endtask

  task automatic drive_c(input logic v, input logic r, input logic [7:0] d);
    valid_c  = v;
    iready_c = r;
    data_c   = d;
    #1;
    check("c_valid", {31'd0, ovalid_c}, {31'd0, v});
    check("c_ready", {31'd0, ready_c}, {31'd0, r});
    check("c_data", {24'd0, odata_c}, {24'd0, d});
    check("c_occ", {31'd0, occ_c}, 32'd0);
  endtask

  initial begin
    int acc0, n;
    rst = 1'b1;
    valid_a = 0; iready_a = 0; data_a = 0;
    valid_b = 0; iready_b = 0; data_b = 0;
    valid_c = 0; iready_c = 0; data_c = 0;
    repeat (3) tick();
    check("rst_a_valid", {31'd0, ovalid_a}, 32'd0);
    check("rst_a_ready", {31'd0, ready_a}, 32'd1);
    check("rst_a_occ", {28'd0, occ_a}, 32'd0);
    check("rst_a_data", {24'd0, odata_a}, 32'd0);
    check("rst_b_valid", {31'd0, ovalid_b}, 32'd0);
    check("rst_b_ready", {31'd0, ready_b}, 32'd1);
    rst = 1'b0;

    // 1: streaming through the skid chain, latency 4, no gaps
    iready_a = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      valid_a = (e <= 16);
      data_a  = 8'(e);
      tick();
      check("p1_valid", {31'd0, ovalid_a}, {31'd0, (e >= 4 && e <= 19)});
      if (e >= 4 && e <= 19) check("p1_data", {24'd0, odata_a}, 32'(e - 3));
      check("p1_ready", {31'd0, ready_a}, 32'd1);
    end
    drain_a("p1_drain");

    // 2: fill under backpressure, capacity 8, then drain
    iready_a = 1'b0;
    valid_a  = 1'b1;
    acc0     = acc_a;
    for (int e = 1; e <= 12; e++) begin
      data_a = 8'(8'h20 + e);
      tick();
      check("p2_ready", {31'd0, ready_a}, {31'd0, e < 8});
    end
    check("p2_accepted", 32'(acc_a - acc0), 32'd8);
    check("p2_occ_full", {28'd0, occ_a}, OCC_ON ? 32'd8 : 32'd0);
    check("p2_valid", {31'd0, ovalid_a}, 32'd1);
    valid_a  = 1'b0;
    iready_a = 1'b1;
    drain_a("p2_drain");
    check("p2_occ_empty", {28'd0, occ_a}, 32'd0);
    check("p2_ready_after", {31'd0, ready_a}, 32'd1);

    // 4: reset with 5 entries held; old words must vanish
    iready_a = 1'b0;
    valid_a  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_a = 8'(8'h40 + i);
      tick();
    end
    check("p4_occ_5", {28'd0, occ_a}, OCC_ON ? 32'd5 : 32'd0);
    valid_a = 1'b0;
    rst     = 1'b1;
    tick();
    exp_a.delete();
    check("p4_valid", {31'd0, ovalid_a}, 32'd0);
    check("p4_occ", {28'd0, occ_a}, 32'd0);
    check("p4_ready", {31'd0, ready_a}, 32'd1);
    rst      = 1'b0;
    iready_a = 1'b1;
    valid_a  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_a = 8'(8'h50 + i);
      tick();
    end
    valid_a = 1'b0;
    drain_a("p4_drain");

    // 3: random handshakes on the single-entry chain
    n = 0;
    while (out_b < 1000 && n < 20000) begin
      if (!valid_b || acc_last_b) begin
        valid_b = 1'($urandom_range(0, 1));
        data_b  = 8'($urandom_range(0, 255));
      end
      iready_b = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("p3_budget", {31'd0, out_b >= 1000}, 32'd1);
    valid_b  = 1'b0;
    iready_b = 1'b1;
    n = 0;
    while ((exp_b.size() != 0 || ovalid_b) && n < 20) begin
      tick();
      n++;
    end
    check("p3_drain", {31'd0, n < 20}, 32'd1);

    // 5: combinational pass-through
    drive_c(1'b1, 1'b0, 8'hA5);
    drive_c(1'b0, 1'b1, 8'h3C);
    drive_c(1'b1, 1'b1, 8'hFF);
    drive_c(1'b0, 1'b0, 8'h00);

    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
